// File: rtl/ocl_arb_pkg.sv
// Shared types and constants for the OCL AXI-Lite arbiter: FSM states, grant
// encoding, AXI response codes and the data word returned on a timeout.
package ocl_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP_B,
    RESP_R
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ocl_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read). On a tie the requester
// that did not win last time is granted; last_grant resets to READ.
module ocl_rr_arb2
  import ocl_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  input  logic accept_i,
  output logic gnt_valid_o,
  output logic gnt_write_o
);

  grant_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_valid_o  = wr_req_i | rd_req_i;
    gnt_write_o  = wr_req_i;
    last_grant_d = last_grant_q;
    if (wr_req_i && rd_req_i) begin
      gnt_write_o = (last_grant_q == READ);
    end
    if (accept_i && gnt_valid_o) begin
      last_grant_d = gnt_write_o ? WRITE : READ;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= READ;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ocl_axil_arbiter.sv
// OCL AXI-Lite slave front end: buffers AW/W/AR, serialises one register request
// at a time and returns B/R. Optional response timeout under OCL_TIMEOUT_EN.
module ocl_axil_arbiter
  import ocl_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk_main_a0,
  input  logic                rst_main,
  input  logic                sh_ocl_awvalid,
  input  logic [31:0]         sh_ocl_awaddr,
  output logic                ocl_sh_awready,
  input  logic                sh_ocl_wvalid,
  input  logic [DATA_W-1:0]   sh_ocl_wdata,
  input  logic [DATA_W/8-1:0] sh_ocl_wstrb,
  output logic                ocl_sh_wready,
  output logic                ocl_sh_bvalid,
  output logic [1:0]          ocl_sh_bresp,
  input  logic                sh_ocl_bready,
  input  logic                sh_ocl_arvalid,
  input  logic [31:0]         sh_ocl_araddr,
  output logic                ocl_sh_arready,
  output logic                ocl_sh_rvalid,
  output logic [DATA_W-1:0]   ocl_sh_rdata,
  output logic [1:0]          ocl_sh_rresp,
  input  logic                sh_ocl_rready,
  output logic                req_valid,
  output logic                req_write,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_wstrb,
  input  logic                req_ready,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_rdata,
  input  logic                rsp_err
);

  state_t                state_q, state_d;
  logic                  aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_W-1:0]     aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0]     w_data_q;
  logic [DATA_W/8-1:0]   w_strb_q;
  logic                  req_write_q;
  logic [ADDR_W-1:0]     req_addr_q;
  logic [DATA_W-1:0]     req_wdata_q;
  logic [DATA_W/8-1:0]   req_wstrb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            resp_q;
  logic                  gnt_valid, gnt_write, b_done, r_done, rsp_take, timeout_hit;

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign ocl_sh_awready = ~aw_full_q & ~rst_main;
  assign ocl_sh_wready  = ~w_full_q & ~rst_main;
  assign ocl_sh_arready = ~ar_full_q & ~rst_main;

  assign b_done = (state_q == RESP_B) & sh_ocl_bready;
  assign r_done = (state_q == RESP_R) & sh_ocl_rready;

  ocl_rr_arb2 u_rr_arb (
    .clk_i       (clk_main_a0),
    .rst_i       (rst_main),
    .wr_req_i    (aw_full_q & w_full_q),
    .rd_req_i    (ar_full_q),
    .accept_i    (state_q == IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_write_o (gnt_write)
  );

`ifdef OCL_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == WAIT_RSP) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == WAIT_RSP) && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rsp_take = 1'b0;
    case (state_q)
      IDLE:     if (gnt_valid) state_d = ISSUE;
      ISSUE:    if (req_ready) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_valid || timeout_hit) begin
          rsp_take = 1'b1;
          state_d  = req_write_q ? RESP_B : RESP_R;
        end
      end
      RESP_B:   if (sh_ocl_bready) state_d = IDLE;
      RESP_R:   if (sh_ocl_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers stay full until their response handshake completes.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (sh_ocl_awvalid && ocl_sh_awready) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= sh_ocl_awaddr[ADDR_W-1:0];
      end else if (b_done) begin
        aw_full_q <= 1'b0;
      end
      if (sh_ocl_wvalid && ocl_sh_wready) begin
        w_full_q <= 1'b1;
        w_data_q <= sh_ocl_wdata;
        w_strb_q <= sh_ocl_wstrb;
      end else if (b_done) begin
        w_full_q <= 1'b0;
      end
      if (sh_ocl_arvalid && ocl_sh_arready) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= sh_ocl_araddr[ADDR_W-1:0];
      end else if (r_done) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  // A real rsp_valid wins over a timeout landing in the same cycle.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        req_write_q <= gnt_write;
        req_addr_q  <= gnt_write ? aw_addr_q : ar_addr_q;
        req_wdata_q <= w_data_q;
        req_wstrb_q <= w_strb_q;
      end
      if (rsp_take) begin
        if (rsp_valid) begin
          rdata_q <= rsp_rdata;
          resp_q  <= rsp_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
          rdata_q <= DATA_W'(TIMEOUT_DATA);
          resp_q  <= RESP_SLVERR;
        end
      end
    end
  end

  assign req_valid     = (state_q == ISSUE);
  assign req_write     = req_write_q;
  assign req_addr      = req_addr_q;
  assign req_wdata     = req_wdata_q;
  assign req_wstrb     = req_wstrb_q;
  assign ocl_sh_bvalid = (state_q == RESP_B);
  assign ocl_sh_bresp  = resp_q;
  assign ocl_sh_rvalid = (state_q == RESP_R);
  assign ocl_sh_rdata  = rdata_q;
  assign ocl_sh_rresp  = resp_q;

endmodule

// File: tb/tb_ocl_axil_arbiter.sv
// Directed self-checking bench for ocl_axil_arbiter; the timeout scenario
// follows OCL_TIMEOUT_EN.
module tb_ocl_axil_arbiter;

  logic        clk = 1'b0;
  logic        rst_main;
  logic        sh_ocl_awvalid, sh_ocl_wvalid, sh_ocl_arvalid, sh_ocl_bready, sh_ocl_rready;
  logic [31:0] sh_ocl_awaddr, sh_ocl_araddr, sh_ocl_wdata, rsp_rdata;
  logic [3:0]  sh_ocl_wstrb;
  logic        ocl_sh_awready, ocl_sh_wready, ocl_sh_arready, ocl_sh_bvalid, ocl_sh_rvalid;
  logic [1:0]  ocl_sh_bresp, ocl_sh_rresp;
  logic [31:0] ocl_sh_rdata, req_addr, req_wdata;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_err;
  logic [3:0]  req_wstrb;
  logic [110:0] allOut;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ocl_axil_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk_main_a0(clk), .rst_main(rst_main),
    .sh_ocl_awvalid(sh_ocl_awvalid), .sh_ocl_awaddr(sh_ocl_awaddr), .ocl_sh_awready(ocl_sh_awready),
    .sh_ocl_wvalid(sh_ocl_wvalid), .sh_ocl_wdata(sh_ocl_wdata), .sh_ocl_wstrb(sh_ocl_wstrb),
    .ocl_sh_wready(ocl_sh_wready), .ocl_sh_bvalid(ocl_sh_bvalid), .ocl_sh_bresp(ocl_sh_bresp),
    .sh_ocl_bready(sh_ocl_bready), .sh_ocl_arvalid(sh_ocl_arvalid), .sh_ocl_araddr(sh_ocl_araddr),
    .ocl_sh_arready(ocl_sh_arready), .ocl_sh_rvalid(ocl_sh_rvalid), .ocl_sh_rdata(ocl_sh_rdata),
    .ocl_sh_rresp(ocl_sh_rresp), .sh_ocl_rready(sh_ocl_rready),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  assign allOut = {ocl_sh_awready, ocl_sh_wready, ocl_sh_bvalid, ocl_sh_bresp, ocl_sh_arready,
                   ocl_sh_rvalid, ocl_sh_rdata, ocl_sh_rresp, req_valid, req_write, req_addr,
                   req_wdata, req_wstrb};

  // Every step lands 1 time unit after a rising edge: inputs change and outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    sh_ocl_awvalid = 0; sh_ocl_wvalid = 0; sh_ocl_arvalid = 0;
    sh_ocl_bready = 0; sh_ocl_rready = 0;
    sh_ocl_awaddr = 0; sh_ocl_araddr = 0; sh_ocl_wdata = 0; sh_ocl_wstrb = 0;
    req_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0;
  endtask

  task automatic doReset();
    rst_main = 1;
    clearInputs();
    tick();
    rst_main = 0;
  endtask

  task automatic waitReq(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_main = 1;
    clearInputs();
    #2;
    compared++;
    if (allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
    end
    tick();
    rst_main = 0;
    #1;
    compared++;
    if ({ocl_sh_awready, ocl_sh_wready, ocl_sh_arready} !== 3'b111 || req_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got aw/w/ar ready %b req_valid %b expected 111 0",
               {ocl_sh_awready, ocl_sh_wready, ocl_sh_arready}, req_valid);
    end
  endtask

  task automatic test_single_write();
    req_ready = 1;
    sh_ocl_bready = 0;
    sh_ocl_awvalid = 1; sh_ocl_awaddr = 32'h10;
    tick();
    sh_ocl_awvalid = 0;
    tick();
    tick();
    sh_ocl_wvalid = 1; sh_ocl_wdata = 32'hA5A5_0001; sh_ocl_wstrb = 4'hF;
    tick();
    sh_ocl_wvalid = 0;
    compared++;
    if (req_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL t1_no_early_req: got %b expected 0", req_valid);
    end
    tick();
    compared++;
    if ({req_valid, req_write, req_addr, req_wdata, req_wstrb} !== {1'b1, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF}) begin
      mismatched++;
      $display("[TB] FAIL t1_req: got v%b w%b a%h d%h s%h expected v1 w1 a10 dA5A50001 sF",
               req_valid, req_write, req_addr, req_wdata, req_wstrb);
    end
    tick();
    rsp_valid = 1; rsp_err = 0; rsp_rdata = 32'h0;
    compared++;
    if (req_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL t1_single_req: got req_valid %b expected 0", req_valid);
    end
    tick();
    rsp_valid = 0;
    compared++;
    if ({ocl_sh_bvalid, ocl_sh_bresp, ocl_sh_awready} !== {1'b1, 2'b00, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL t1_bresp: got bvalid %b bresp %b awready %b expected 1 00 0",
               ocl_sh_bvalid, ocl_sh_bresp, ocl_sh_awready);
    end
    sh_ocl_bready = 1;
    tick();
    sh_ocl_bready = 0;
    compared++;
    if ({ocl_sh_bvalid, ocl_sh_awready, ocl_sh_wready} !== 3'b011) begin
      mismatched++;
      $display("[TB] FAIL t1_b_done: got bvalid/awready/wready %b expected 011",
               {ocl_sh_bvalid, ocl_sh_awready, ocl_sh_wready});
    end
  endtask

  task automatic test_round_robin();
    bit          grants [4];
    logic [31:0] addrs  [4];
    int          nGrants = 0;
    bit          sawReq = 0;
    doReset();
    req_ready = 1; sh_ocl_bready = 1; sh_ocl_rready = 1;
    sh_ocl_awvalid = 1; sh_ocl_awaddr = 32'h100;
    sh_ocl_wvalid = 1; sh_ocl_wdata = 32'h0000_0BAD; sh_ocl_wstrb = 4'hF;
    sh_ocl_arvalid = 1; sh_ocl_araddr = 32'h20;
    for (int n = 0; n < 100 && nGrants < 4; n++) begin
      tick();
      rsp_valid = sawReq;
      sawReq = 0;
      if (req_valid) begin
        grants[nGrants] = req_write;
        addrs[nGrants] = req_addr;
        nGrants++;
        sawReq = 1;
      end
    end
    rsp_valid = 0;
    sh_ocl_awvalid = 0; sh_ocl_wvalid = 0; sh_ocl_arvalid = 0;
    compared++;
    if (nGrants != 4) begin
      mismatched++;
      $display("[TB] FAIL t2_grant_count: got %0d expected 4", nGrants);
    end else begin
      compared++;
      if ({grants[0], grants[1], grants[2], grants[3]} !== 4'b1010) begin
        mismatched++;
        $display("[TB] FAIL t2_order: got %b expected 1010 (W,R,W,R)",
                 {grants[0], grants[1], grants[2], grants[3]});
      end
      compared++;
      if (addrs[0] !== 32'h100 || addrs[1] !== 32'h20) begin
        mismatched++;
        $display("[TB] FAIL t2_addrs: got %h %h expected 100 20", addrs[0], addrs[1]);
      end
    end
    doReset();
  endtask

  task automatic test_read_error_hold();
    bit ok;
    req_ready = 1;
    sh_ocl_arvalid = 1; sh_ocl_araddr = 32'h30;
    tick();
    sh_ocl_arvalid = 0;
    waitReq(ok);
    compared++;
    if (!ok || req_write !== 1'b0 || req_addr !== 32'h30) begin
      mismatched++;
      $display("[TB] FAIL t3_req: got found %b write %b addr %h expected 1 0 30", ok, req_write, req_addr);
    end
    tick();
    rsp_valid = 1; rsp_err = 1; rsp_rdata = 32'h1234;
    tick();
    rsp_valid = 0; rsp_err = 0; rsp_rdata = 32'h0;
    compared++;
    if ({ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata} !== {1'b1, 2'b10, 32'h1234}) begin
      mismatched++;
      $display("[TB] FAIL t3_rresp: got rvalid %b rresp %b rdata %h expected 1 10 1234",
               ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if ({ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata, ocl_sh_arready} !== {1'b1, 2'b10, 32'h1234, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL t3_hold%0d: got rvalid %b rresp %b rdata %h arready %b expected 1 10 1234 0",
                 i, ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata, ocl_sh_arready);
      end
    end
    sh_ocl_rready = 1;
    tick();
    sh_ocl_rready = 0;
    compared++;
    if ({ocl_sh_rvalid, ocl_sh_arready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL t3_r_done: got rvalid/arready %b expected 01", {ocl_sh_rvalid, ocl_sh_arready});
    end
  endtask

  task automatic test_issue_stall();
    bit ok;
    req_ready = 0;
    sh_ocl_awvalid = 1; sh_ocl_awaddr = 32'h44;
    sh_ocl_wvalid = 1; sh_ocl_wdata = 32'hCAFE_0004; sh_ocl_wstrb = 4'b0011;
    tick();
    sh_ocl_awvalid = 0; sh_ocl_wvalid = 0;
    waitReq(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL t4_req_seen: got none expected req_valid");
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      rsp_valid = (i == 2); rsp_err = (i == 2); rsp_rdata = 32'hFFFF_FFFF;
      compared++;
      if ({req_valid, req_write, req_addr, req_wdata, req_wstrb} !== {1'b1, 1'b1, 32'h44, 32'hCAFE_0004, 4'b0011}) begin
        mismatched++;
        $display("[TB] FAIL t4_stall%0d: got v%b w%b a%h d%h s%h expected v1 w1 a44 dCAFE0004 s3",
                 i, req_valid, req_write, req_addr, req_wdata, req_wstrb);
      end
    end
    rsp_valid = 0; rsp_err = 0;
    req_ready = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({req_valid, ocl_sh_bvalid} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL t4_wait%0d: got req_valid/bvalid %b expected 00", i, {req_valid, ocl_sh_bvalid});
      end
    end
    rsp_valid = 1; rsp_err = 0;
    tick();
    rsp_valid = 0;
    compared++;
    if ({ocl_sh_bvalid, ocl_sh_bresp} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL t4_bresp: got bvalid %b bresp %b expected 1 00", ocl_sh_bvalid, ocl_sh_bresp);
    end
    sh_ocl_bready = 1;
    tick();
    sh_ocl_bready = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    req_ready = 1;
    sh_ocl_arvalid = 1; sh_ocl_araddr = 32'h50;
    tick();
    sh_ocl_arvalid = 0;
    waitReq(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL t5_req_seen: got none expected req_valid");
    end
`ifdef OCL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) tick();
    compared++;
    if (ocl_sh_rvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL t5_early: got rvalid %b expected 0", ocl_sh_rvalid);
    end
    tick();
    compared++;
    if ({ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata} !== {1'b1, 2'b10, 32'hDEAD_BEEF}) begin
      mismatched++;
      $display("[TB] FAIL t5_timeout: got rvalid %b rresp %b rdata %h expected 1 10 deadbeef",
               ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata);
    end
`else
    begin
      bit stillWaiting = 1;
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (ocl_sh_rvalid !== 1'b0) stillWaiting = 0;
      end
      compared++;
      if (!stillWaiting) begin
        mismatched++;
        $display("[TB] FAIL t5_no_timeout: got rvalid during 1000 cycles expected none");
      end
    end
    rsp_valid = 1; rsp_err = 0; rsp_rdata = 32'h5555_AAAA;
    tick();
    rsp_valid = 0;
    compared++;
    if ({ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata} !== {1'b1, 2'b00, 32'h5555_AAAA}) begin
      mismatched++;
      $display("[TB] FAIL t5_late_rsp: got rvalid %b rresp %b rdata %h expected 1 00 5555aaaa",
               ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata);
    end
`endif
    sh_ocl_rready = 1;
    tick();
    sh_ocl_rready = 0;
  endtask

  task automatic test_reset_midflight();
    bit ok;
    req_ready = 1;
    sh_ocl_arvalid = 1; sh_ocl_araddr = 32'h60;
    tick();
    sh_ocl_arvalid = 0;
    waitReq(ok);
    tick();
    #3;
    rst_main = 1;
    #1;
    compared++;
    if (!ok || allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL t6_async_reset: got found %b outputs %h expected 1 0", ok, allOut);
    end
    @(posedge clk);
    #1;
    rst_main = 0;
    rsp_valid = 1; rsp_rdata = 32'hBAD0_0BAD;
    tick();
    rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({ocl_sh_rvalid, ocl_sh_bvalid, req_valid, ocl_sh_arready} !== 4'b0001) begin
        mismatched++;
        $display("[TB] FAIL t6_abandoned%0d: got rvalid/bvalid/req_valid/arready %b expected 0001",
                 i, {ocl_sh_rvalid, ocl_sh_bvalid, req_valid, ocl_sh_arready});
      end
      tick();
    end
    sh_ocl_arvalid = 1; sh_ocl_araddr = 32'h40;
    tick();
    sh_ocl_arvalid = 0;
    waitReq(ok);
    compared++;
    if (!ok || req_write !== 1'b0 || req_addr !== 32'h40) begin
      mismatched++;
      $display("[TB] FAIL t6_new_req: got found %b write %b addr %h expected 1 0 40", ok, req_write, req_addr);
    end
    tick();
    rsp_valid = 1; rsp_rdata = 32'h77;
    tick();
    rsp_valid = 0;
    compared++;
    if ({ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata} !== {1'b1, 2'b00, 32'h77}) begin
      mismatched++;
      $display("[TB] FAIL t6_new_rsp: got rvalid %b rresp %b rdata %h expected 1 00 77",
               ocl_sh_rvalid, ocl_sh_rresp, ocl_sh_rdata);
    end
    sh_ocl_rready = 1;
    tick();
    sh_ocl_rready = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_error_hold();
    test_issue_stall();
    test_timeout();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
